// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic {RUN, HALTED} fetch_state_t;
  localparam word_t NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if_id_latch.sv
// fetch_stage_if_id_latch: IF/ID pipeline register with hold, bubble and load controls.
module fetch_stage_if_id_latch
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP = NOP_WORD
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  logic  load_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o,
  output logic  valid_o
);
  word_t instr_q, npc_q;
  logic  valid_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      instr_q <= NOP;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      instr_q <= instr_q;
    end else if (bubble_i) begin
      instr_q <= NOP;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      npc_q   <= npc_i;
      valid_q <= 1'b1;
    end
  end
  assign instr_o = instr_q;
  assign npc_o   = npc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, fetch state machine and redirect/halt/stall/miss priority
// feeding the IF/ID latch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0000_0000,
  parameter word_t NOP_INSTR = NOP_WORD
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt_in,
  output logic  imemREN,
  output word_t imemaddr,
  output word_t instr_out,
  output word_t npc_out,
  output logic  valid_out,
  output logic  halted
);
  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d, pc_plus4;
  logic         hold, bubble, load;
  assign pc_plus4 = pc_q + 32'd4;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= PC_INIT & 32'hFFFF_FFFC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  // A redirect wins over halt_in: a halt decoded in the same cycle is on the wrong path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold    = 1'b0;
    bubble  = 1'b0;
    load    = 1'b0;
    if (state_q == HALTED) begin
      hold = 1'b1;
    end else if (redirect) begin
      pc_d   = redirect_pc & 32'hFFFF_FFFC;
      bubble = 1'b1;
    end else if (halt_in) begin
      state_d = HALTED;
      bubble  = 1'b1;
    end else if (stall) begin
      hold = 1'b1;
    end else if (ihit) begin
      load = 1'b1;
      pc_d = pc_plus4;
    end else begin
      bubble = 1'b1;
    end
  end
  fetch_stage_if_id_latch #(.NOP(NOP_INSTR)) u_if_id (
    .CLK      (CLK),
    .RST      (RST),
    .hold_i   (hold),
    .bubble_i (bubble),
    .load_i   (load),
    .instr_i  (iload),
    .npc_i    (pc_plus4),
    .instr_o  (instr_out),
    .npc_o    (npc_out),
    .valid_o  (valid_out)
  );
  assign imemREN  = (state_q == RUN);
  assign imemaddr = pc_q;
  assign halted   = (state_q == HALTED);
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register for the pipelined MIPS core.
- Owns the PC and drives instruction-memory requests.
- Holds the fetched word and PC+4 in the IF/ID latch; the latched word feeds the control unit's instruction input.
- Honours hazard-unit stalls, branch/jump redirects from later stages, and the decoded halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) inserted into IF/ID.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
ihit  in  1  instruction memory returned valid data this cycle.
iload  in  32  instruction word from memory.
stall  in  1  hazard unit: hold PC and IF/ID.
redirect  in  1  taken branch or jump resolved downstream.
redirect_pc  in  32  target PC for a redirect.
halt_in  in  1  decoded halt from the ID-stage control unit.
imemREN  out  1  instruction read enable.
imemaddr  out  32  instruction address (equals the PC).
instr_out  out  32  IF/ID instruction, to the control unit.
npc_out  out  32  IF/ID PC+4.
valid_out  out  1  IF/ID holds a real (non-bubble) instruction.
halted  out  1  fetch is frozen in the HALTED state.

Behaviour:
- Reset (asynchronous, any time, including mid-miss or mid-stall):
  - PC=PC_INIT, instr_out=NOP_INSTR, npc_out=0, valid_out=0.
  - State=RUN, so imemREN=1 and halted=0.
  - The first request (address PC_INIT) is issued in the first cycle after RST deasserts.
- States: RUN, HALTED.
- Outputs per state:
  - RUN: imemREN=1, imemaddr=PC.
  - HALTED: imemREN=0, imemaddr=PC (frozen).
- Per-edge update priority in RUN: redirect > halt_in > stall > ihit > miss.
  - redirect: PC <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (NOP_INSTR, npc 0, valid 0); state stays RUN. Redirect overrides stall and halt_in in the same cycle, because that halt sits on the wrong path.
  - halt_in (no redirect): state <= HALTED; IF/ID <= bubble; PC holds.
  - stall (no redirect, no halt_in): PC and IF/ID hold. Any ihit this cycle is discarded, and the same address is refetched.
  - ihit: IF/ID <= {iload, PC+4, valid 1}; PC <= PC+4.
  - miss (!ihit): IF/ID <= bubble; PC holds; imemaddr stays stable until ihit.
- HALTED:
  - PC and IF/ID are frozen; the latch holds the bubble written on entry.
  - All inputs except RST are ignored. Only RST leaves HALTED.
  - halted=1 is registered, visible the cycle after halt_in is sampled.
- Arithmetic:
  - PC+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
  - PC[1:0] is always 2'b00; redirect_pc[1:0] is ignored.
- Latency: an instruction is visible on instr_out one cycle after the edge where ihit was sampled with no stall and no redirect.
- valid_out=0 exactly when instr_out carries the inserted bubble.

Decomposition:
- cpu_types_pkg additions:
  - fetch_state_t enum {RUN, HALTED}.
  - NOP_INSTR constant.
  - word_t is reused for all 32-bit buses.
- fetch_if interface in include/, with modports fs and tb.
- One sub-module: if_id_latch.
  - Holds instr/npc/valid with hold, bubble, load and async reset controls.
  - The top level holds the PC, the state machine and the priority logic.

Test Plan:
1. Reset, then ihit=1 every cycle with iload = address-tagged words -> imemaddr steps 0,4,8,12; instr_out lags one cycle; npc_out = addr+4; valid_out=1.
2. ihit low for 3 cycles at PC=8 -> imemaddr held at 8; valid_out=0 for 3 cycles; on ihit, instr_out=word@8 and npc_out=12.
3. stall=1 for 2 cycles with ihit=1 at PC=16 -> PC stays 16 and IF/ID unchanged; on release, word@16 loads, then PC=20.
4. redirect=1, redirect_pc=32'h0000_0103, together with stall=1 and halt_in=1 -> next PC=32'h100; IF/ID is a bubble; state stays RUN; halted=0.
5. halt_in=1 alone -> next cycle halted=1, imemREN=0, PC frozen; ihit/redirect toggling has no effect; RST returns PC=PC_INIT and imemREN=1.
6. Redirect to 32'hFFFF_FFFC with ihit -> npc_out=0 and next imemaddr=0. Then assert RST asynchronously mid-cycle during a miss -> outputs take reset values immediately, without waiting for CLK.
